// File: rtl/eeprom_iic_arbiter_pkg.sv
// Shared types and iic_com command codes for the EEPROM I2C arbiter.
// Start_Sig encodings follow the iic_com engine interface.
package eeprom_iic_arbiter_pkg;

    localparam logic [1:0] IIC_IDLE = 2'b00;
    localparam logic [1:0] IIC_WR   = 2'b01;
    localparam logic [1:0] IIC_RD   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WR_GAP    = 3'd4
    } arb_state_t;

    function automatic logic [1:0] start_code(input logic wr);
        return wr ? IIC_WR : IIC_RD;
    endfunction

endpackage

// File: rtl/eeprom_iic_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational; the last-grant pointer
// lives in the parent so it only moves when a grant is actually taken.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_vld,
    output logic       o_gnt
);

    // On a tie the requester that did not win last time gets the bus.
    assign o_vld = |i_req;
    assign o_gnt = (&i_req) ? ~i_last : i_req[1];

endmodule

// File: rtl/eeprom_iic_arbiter.sv
// Shares one iic_com EEPROM engine between two requesters with round-robin
// arbitration, a done-timeout and the post-write tWR gap.
module eeprom_iic_arbiter
    import eeprom_iic_arbiter_pkg::*;
#(
    parameter int unsigned      CNT_W       = 20,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = 20'd1000000,
    parameter logic [CNT_W-1:0] WR_GAP_CYC  = 20'd250000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [1:0]  Req,
    input  logic [1:0]  ReqWr,
    input  logic [15:0] ReqAddr,
    input  logic [15:0] ReqWrData,
    output logic [1:0]  Ack,
    output logic        Err,
    output logic [7:0]  RdData_o,
    output logic        Busy,
    output logic [1:0]  Start_Sig,
    output logic [7:0]  Addr_Sig,
    output logic [7:0]  WrData,
    input  logic [7:0]  RdData,
    input  logic        Done_Sig
);

    arb_state_t       r_state, w_state_nxt;
    logic             r_last;
    logic             r_g;
    logic             r_wr;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ack;
    logic             r_err;
    logic [7:0]       r_rdata;
    logic [1:0]       r_start;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdat;

    logic             w_gnt_vld;
    logic             w_gnt;
    logic             w_done_ev;
    logic             w_tmo;
    logic             w_gap_end;

    rr_arb2 u_rr_arb2 (
        .i_req  (Req),
        .i_last (r_last),
        .o_vld  (w_gnt_vld),
        .o_gnt  (w_gnt)
    );

    // Done takes priority over a timeout landing on the same edge.
    assign w_done_ev = (r_state == ST_WAIT_DONE) && Done_Sig;
    assign w_tmo     = (r_state == ST_WAIT_DONE) && !Done_Sig &&
                       (r_cnt == TIMEOUT_CYC - 1'b1);
    assign w_gap_end = (r_state == ST_WR_GAP) && (r_cnt == WR_GAP_CYC - 1'b1);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_gnt_vld) w_state_nxt = ST_ISSUE;
            ST_ISSUE:     w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (w_done_ev || w_tmo) w_state_nxt = ST_RELEASE;
            // r_err is the flag of the transaction that just finished.
            ST_RELEASE:   w_state_nxt = (r_wr && !r_err) ? ST_WR_GAP : ST_IDLE;
            ST_WR_GAP:    if (w_gap_end) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_last  <= 1'b1;
            r_g     <= 1'b0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_ack   <= 2'b00;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
            r_start <= IIC_IDLE;
            r_addr  <= 8'h00;
            r_wdat  <= 8'h00;
        end else begin
            r_ack <= 2'b00;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_g    <= w_gnt;
                        r_last <= w_gnt;
                        r_wr   <= ReqWr[w_gnt];
                        r_addr <= w_gnt ? ReqAddr[15:8]   : ReqAddr[7:0];
                        r_wdat <= w_gnt ? ReqWrData[15:8] : ReqWrData[7:0];
                    end
                end
                ST_ISSUE: begin
                    r_start <= start_code(r_wr);
                    r_cnt   <= '0;
                end
                ST_WAIT_DONE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done_ev) begin
                        r_start    <= IIC_IDLE;
                        r_ack[r_g] <= 1'b1;
                        if (!r_wr) r_rdata <= RdData;
                    end else if (w_tmo) begin
                        r_start    <= IIC_IDLE;
                        r_ack[r_g] <= 1'b1;
                        r_err      <= 1'b1;
                    end
                end
                ST_RELEASE: r_cnt <= '0;
                ST_WR_GAP:  r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign Ack       = r_ack;
    assign Err       = r_err;
    assign RdData_o  = r_rdata;
    assign Busy      = (r_state != ST_IDLE);
    assign Start_Sig = r_start;
    assign Addr_Sig  = r_addr;
    assign WrData    = r_wdat;

endmodule

// File: tb/tb_eeprom_iic_arbiter.sv
// Directed bench for eeprom_iic_arbiter with a hand-driven Done_Sig/RdData stub.
module tb_eeprom_iic_arbiter;

    localparam logic [19:0] TMO = 20'd16;
    localparam logic [19:0] GAP = 20'd8;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [1:0]  Req;
    logic [1:0]  ReqWr;
    logic [15:0] ReqAddr;
    logic [15:0] ReqWrData;
    logic [1:0]  Ack;
    logic        Err;
    logic [7:0]  RdData_o;
    logic        Busy;
    logic [1:0]  Start_Sig;
    logic [7:0]  Addr_Sig;
    logic [7:0]  WrData;
    logic [7:0]  RdData;
    logic        Done_Sig;

    int checks   = 0;
    int failures = 0;

    eeprom_iic_arbiter #(
        .CNT_W       (20),
        .TIMEOUT_CYC (TMO),
        .WR_GAP_CYC  (GAP)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Req       (Req),
        .ReqWr     (ReqWr),
        .ReqAddr   (ReqAddr),
        .ReqWrData (ReqWrData),
        .Ack       (Ack),
        .Err       (Err),
        .RdData_o  (RdData_o),
        .Busy      (Busy),
        .Start_Sig (Start_Sig),
        .Addr_Sig  (Addr_Sig),
        .WrData    (WrData),
        .RdData    (RdData),
        .Done_Sig  (Done_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges until Start_Sig leaves idle (40 = expired).
    task automatic wait_start(output int n);
        n = 0;
        while (Start_Sig == 2'b00 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // One-cycle Done pulse with read data; returns at the negedge Ack is visible.
    task automatic do_done(input logic [7:0] rd);
        Done_Sig = 1'b1;
        RdData   = rd;
        tick();
        Done_Sig = 1'b0;
        RdData   = 8'hEE;
    endtask

    initial begin
        int n;
        int busy_n;
        logic [7:0] d;
        RSTn = 1'b0; Req = 2'b00; ReqWr = 2'b00; ReqAddr = 16'h0000;
        ReqWrData = 16'h0000; RdData = 8'hEE; Done_Sig = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_start", Start_Sig, 2'b00);
        chk("rst_ack",   Ack, 2'b00);
        chk("rst_err",   Err, 1'b0);
        chk("rst_busy",  Busy, 1'b0);
        chk("rst_rdata", RdData_o, 8'h00);
        chk("rst_addr",  Addr_Sig, 8'h00);
        RSTn = 1'b1;
        tick();

        // 1: requester 0 writes 0x12 to 0x00
        Req = 2'b01; ReqWr = 2'b01; ReqAddr = 16'h0000; ReqWrData = 16'h0012;
        wait_start(n);
        chk("wr_latency", n, 2);
        chk("wr_start",   Start_Sig, 2'b01);
        chk("wr_addr",    Addr_Sig, 8'h00);
        chk("wr_data",    WrData, 8'h12);
        tick(); tick();
        do_done(8'hEE);
        chk("wr_ack",     Ack, 2'b01);
        chk("wr_err",     Err, 1'b0);
        chk("wr_start0",  Start_Sig, 2'b00);
        // 2: requester 1 read queued immediately; must wait out the write gap
        Req = 2'b10; ReqWr = 2'b00; ReqAddr = 16'h0000;
        busy_n = 0;
        while (busy_n < 100) begin
            tick();
            if (!Busy) break;
            busy_n++;
        end
        chk("gap_busy_cycles", busy_n, GAP);
        chk("gap_ack_clear",   Ack, 2'b00);
        wait_start(n);
        chk("rd_latency", n, 2);
        chk("rd_start",   Start_Sig, 2'b10);
        do_done(8'h12);
        chk("rd_ack",   Ack, 2'b10);
        chk("rd_err",   Err, 1'b0);
        chk("rd_data",  RdData_o, 8'h12);
        Req = 2'b00;
        tick();
        chk("rd_ack_pulse", Ack, 2'b00);

        // 3: both requesters read continuously -> alternate 0,1,0,1
        Req = 2'b11; ReqWr = 2'b00; ReqAddr = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            wait_start(n);
            chk("rr_started", n < 40, 1'b1);
            chk("rr_addr", Addr_Sig, (i % 2 == 0) ? 8'h11 : 8'h22);
            d = 8'hA0 + 8'(i);
            do_done(d);
            chk("rr_ack",   Ack, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rdata", RdData_o, d);
        end
        Req = 2'b00;
        tick(); tick();

        // 4: Done never comes -> timeout after 16 WAIT_DONE cycles
        Req = 2'b01; ReqWr = 2'b00; ReqAddr = 16'h0033;
        wait_start(n);
        chk("tmo_started", n < 40, 1'b1);
        n = 0;
        while (Ack == 2'b00 && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_ack",    Ack, 2'b01);
        chk("tmo_err",    Err, 1'b1);
        chk("tmo_start",  Start_Sig, 2'b00);
        chk("tmo_rdata",  RdData_o, 8'hA3);
        Req = 2'b10;
        tick();
        chk("tmo_err_pulse", Err, 1'b0);
        wait_start(n);
        chk("post_tmo_start", Start_Sig, 2'b10);
        do_done(8'h5A);
        chk("post_tmo_ack",   Ack, 2'b10);
        chk("post_tmo_err",   Err, 1'b0);
        chk("post_tmo_rdata", RdData_o, 8'h5A);
        Req = 2'b00;
        tick(); tick();

        // 5: Done on the same edge as the timeout -> Done wins
        Req = 2'b01; ReqWr = 2'b00; ReqAddr = 16'h0034;
        wait_start(n);
        chk("race_started", n < 40, 1'b1);
        repeat (15) tick();
        chk("race_no_early", Ack, 2'b00);
        do_done(8'h77);
        chk("race_ack",   Ack, 2'b01);
        chk("race_err",   Err, 1'b0);
        chk("race_rdata", RdData_o, 8'h77);
        Req = 2'b00;
        tick(); tick();

        // 6: asynchronous reset during WAIT_DONE
        Req = 2'b01; ReqWr = 2'b01; ReqAddr = 16'h0040; ReqWrData = 16'h0055;
        wait_start(n);
        chk("arst_started", Start_Sig, 2'b01);
        tick(); tick();
        #2 RSTn = 1'b0;
        #1;
        chk("arst_start", Start_Sig, 2'b00);
        chk("arst_ack",   Ack, 2'b00);
        chk("arst_busy",  Busy, 1'b0);
        chk("arst_rdata", RdData_o, 8'h00);
        tick();
        Req = 2'b00;
        RSTn = 1'b1;
        tick();
        Req = 2'b01; ReqWr = 2'b00; ReqAddr = 16'h0044;
        wait_start(n);
        chk("post_rst_latency", n, 2);
        chk("post_rst_start",   Start_Sig, 2'b10);
        chk("post_rst_addr",    Addr_Sig, 8'h44);
        do_done(8'h99);
        chk("post_rst_ack",   Ack, 2'b01);
        chk("post_rst_err",   Err, 1'b0);
        chk("post_rst_rdata", RdData_o, 8'h99);
        Req = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
